// File: rtl/gray_seq_checker_if.sv
// Bus bundle between the Gray counter side and gray_seq_checker.
// master drives samples and observes results; slave is the checker itself.
interface gray_seq_checker_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
);
    logic [WIDTH-1:0] gray_in;
    logic             in_vld;
    logic [WIDTH-1:0] bin_out;
    logic             bin_vld;
    logic             locked;
    logic             step_err;
    logic             wrap;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output gray_in,
        output in_vld,
        input  bin_out,
        input  bin_vld,
        input  locked,
        input  step_err,
        input  wrap,
        input  err_cnt
    );

    modport slave (
        input  gray_in,
        input  in_vld,
        output bin_out,
        output bin_vld,
        output locked,
        output step_err,
        output wrap,
        output err_cnt
    );
endinterface

// File: rtl/gray_seq_checker.sv
// Gray sequence checker: samples a Gray word, decodes it to binary over two
// register stages and checks that consecutive samples hold or step by +1
// (modulo 2^WIDTH). A lock FSM qualifies the stream; a step error seen while
// locked drops lock, pulses step_err and bumps a saturating error count.
module gray_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    gray_seq_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    // Stage 1 sample register
    logic [WIDTH-1:0] g_q;
    logic             v_q;

    // Decoded sample and step classification
    logic [WIDTH-1:0] cur_bin;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_inc;
    logic             is_hold;
    logic             is_good;
    logic             is_bad;

    // Lock FSM
    state_t           state_q;
    state_t           state_d;
    logic [3:0]       gc_q;
    logic [3:0]       gc_d;
    logic [3:0]       gc_inc;
    logic             gc_reach;

    // Stage 2 result registers
    logic [WIDTH-1:0] bin_q;
    logic             bin_vld_q;
    logic             step_err_d;
    logic             step_err_q;
    logic             wrap_d;
    logic             wrap_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic             err_sat;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_decode
        assign cur_bin[i] = ^g_q[WIDTH-1:i];
    end

    // prev+1 is held in a WIDTH-bit net so that all-ones wraps to zero.
    assign prev_inc = prev_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign is_hold  = (cur_bin == prev_q);
    assign is_good  = (cur_bin == prev_inc);
    assign is_bad   = !is_hold && !is_good;

    assign gc_inc   = gc_q + 4'd1;
    assign gc_reach = (gc_inc == 4'(LOCK_CNT));
    assign err_sat  = &err_cnt_q;

    // Stage 1: capture the raw Gray sample and its valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= bus.in_vld;
            if (bus.in_vld) begin
                g_q <= bus.gray_in;
            end
        end
    end

    // FSM state register together with the good-step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UNLOCKED;
            gc_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            gc_q    <= gc_d;
        end
    end

    // Next-state logic; only a decoded sample (v_q) can move the FSM.
    always_comb begin
        state_d = state_q;
        gc_d    = gc_q;
        if (v_q) begin
            case (state_q)
                UNLOCKED: begin
                    state_d = ACQUIRE;
                    gc_d    = 4'd0;
                end
                ACQUIRE: begin
                    if (is_good) begin
                        gc_d = gc_inc;
                        if (gc_reach) begin
                            state_d = LOCKED;
                        end
                    end else if (is_bad) begin
                        gc_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_bad) begin
                        state_d = ACQUIRE;
                        gc_d    = 4'd0;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    gc_d    = 4'd0;
                end
            endcase
        end
    end

    // Output decode; pulses are qualified by the state before the sample.
    always_comb begin
        step_err_d = 1'b0;
        wrap_d     = 1'b0;
        if (v_q && (state_q == LOCKED)) begin
            step_err_d = is_bad;
            wrap_d     = is_good && (&prev_q);
        end
    end

    // Stage 2: register decoded value, result pulses and previous sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q      <= '0;
            bin_vld_q  <= 1'b0;
            step_err_q <= 1'b0;
            wrap_q     <= 1'b0;
            prev_q     <= '0;
        end else begin
            bin_vld_q  <= v_q;
            step_err_q <= step_err_d;
            wrap_q     <= wrap_d;
            if (v_q) begin
                bin_q  <= cur_bin;
                prev_q <= cur_bin;
            end
        end
    end

    // Error counter sticks at all-ones once saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (step_err_d && !err_sat) begin
            err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.bin_vld  = bin_vld_q;
    assign bus.locked   = (state_q == LOCKED);
    assign bus.step_err = step_err_q;
    assign bus.wrap     = wrap_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Self-checking bench for gray_seq_checker. Two instances share the same
// stimulus: one with an 8-bit error counter and one with a 2-bit counter so
// that saturation is reached quickly. Expectations come from a sample-level
// reference model fed with the binary value behind each Gray word.
module tb_gray_seq_checker;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    gray_seq_checker_if #(.WIDTH(W), .ERR_W(8)) bus_a ();
    gray_seq_checker_if #(.WIDTH(W), .ERR_W(2)) bus_b ();

    gray_seq_checker #(.WIDTH(W), .LOCK_CNT(4), .ERR_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    gray_seq_checker #(.WIDTH(W), .LOCK_CNT(4), .ERR_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    typedef struct {
        bit vld;
        int bout;
        bit lk;
        bit serr;
        bit wr;
        int ecnt_a;
        int ecnt_b;
    } exp_t;

    exp_t pipe0;
    exp_t pipe1;

    // Reference model state: 0 = no sample yet, 1 = acquiring, 2 = locked
    int m_mode;
    int m_run;
    int m_prev;
    int m_bout;
    int m_ecnt_a;
    int m_ecnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cur;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t idleRecord();
        exp_t e;
        e.vld    = 1'b0;
        e.bout   = m_bout;
        e.lk     = (m_mode == 2);
        e.serr   = 1'b0;
        e.wr     = 1'b0;
        e.ecnt_a = m_ecnt_a;
        e.ecnt_b = m_ecnt_b;
        return e;
    endfunction

    task automatic modelReset();
        m_mode   = 0;
        m_run    = 0;
        m_prev   = 0;
        m_bout   = 0;
        m_ecnt_a = 0;
        m_ecnt_b = 0;
        pipe0    = idleRecord();
        pipe1    = idleRecord();
    endtask

    // One sample in, the outputs it should produce two edges later out.
    task automatic modelStep(input bit vld, input int b, output exp_t e);
        int  diff;
        bit  serr;
        bit  wr;
        serr = 1'b0;
        wr   = 1'b0;
        if (vld) begin
            diff = (b - m_prev + 256) % 256;
            if (m_mode == 0) begin
                m_mode = 1;
                m_run  = 0;
            end else if (m_mode == 1) begin
                if (diff == 1) begin
                    m_run++;
                    if (m_run == 4) m_mode = 2;
                end else if (diff != 0) begin
                    m_run = 0;
                end
            end else begin
                if (diff > 1) begin
                    serr     = 1'b1;
                    m_ecnt_a = (m_ecnt_a < 255) ? m_ecnt_a + 1 : 255;
                    m_ecnt_b = (m_ecnt_b < 3) ? m_ecnt_b + 1 : 3;
                    m_mode   = 1;
                    m_run    = 0;
                end else if (diff == 1 && m_prev == 255) begin
                    wr = 1'b1;
                end
            end
            m_prev = b;
            m_bout = b;
        end
        e      = idleRecord();
        e.vld  = vld;
        e.serr = serr;
        e.wr   = wr;
    endtask

    task automatic compareAll();
        checkOutput("a.bin_vld",  32'(bus_a.bin_vld),  32'(pipe1.vld));
        checkOutput("a.bin_out",  32'(bus_a.bin_out),  32'(pipe1.bout));
        checkOutput("a.locked",   32'(bus_a.locked),   32'(pipe1.lk));
        checkOutput("a.step_err", 32'(bus_a.step_err), 32'(pipe1.serr));
        checkOutput("a.wrap",     32'(bus_a.wrap),     32'(pipe1.wr));
        checkOutput("a.err_cnt",  32'(bus_a.err_cnt),  32'(pipe1.ecnt_a));
        checkOutput("b.locked",   32'(bus_b.locked),   32'(pipe1.lk));
        checkOutput("b.step_err", 32'(bus_b.step_err), 32'(pipe1.serr));
        checkOutput("b.err_cnt",  32'(bus_b.err_cnt),  32'(pipe1.ecnt_b));
    endtask

    // Drive one cycle at the falling edge, checking the results due now first.
    task automatic applyStimulus(input bit vld, input int b);
        exp_t e;
        logic [W-1:0] g;
        @(negedge clk);
        compareAll();
        pipe1 = pipe0;
        g = W'(b ^ (b >> 1));
        bus_a.gray_in = g;
        bus_b.gray_in = g;
        bus_a.in_vld  = vld;
        bus_b.in_vld  = vld;
        modelStep(vld, b, e);
        pipe0 = e;
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst.bin_vld",  32'(bus_a.bin_vld),  32'd0);
        checkOutput("rst.bin_out",  32'(bus_a.bin_out),  32'd0);
        checkOutput("rst.locked",   32'(bus_a.locked),   32'd0);
        checkOutput("rst.step_err", 32'(bus_a.step_err), 32'd0);
        checkOutput("rst.wrap",     32'(bus_a.wrap),     32'd0);
        checkOutput("rst.err_cnt",  32'(bus_a.err_cnt),  32'd0);
        checkOutput("rst.b_err",    32'(bus_b.err_cnt),  32'd0);
        bus_a.in_vld = 1'b0;
        bus_b.in_vld = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        bus_a.gray_in = '0;
        bus_b.gray_in = '0;
        bus_a.in_vld  = 1'b0;
        bus_b.in_vld  = 1'b0;
        modelReset();

        doReset();

        // Lock on 0..4
        for (int v = 0; v <= 4; v++) applyStimulus(1'b1, v);

        // Wrap through all-ones, then reset with a sample in flight
        doReset();
        for (int v = 250; v <= 257; v++) applyStimulus(1'b1, v % 256);
        doReset();

        // Holds and gaps while locked, then a skip and relock
        for (int v = 6; v <= 10; v++) applyStimulus(1'b1, v);
        applyStimulus(1'b1, 10);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 0);
        for (int v = 11; v <= 20; v++) applyStimulus(1'b1, v);
        applyStimulus(1'b1, 22);
        for (int v = 23; v <= 26; v++) applyStimulus(1'b1, v);

        // Four lock-then-skip episodes to saturate the 2-bit counter
        doReset();
        for (int ep = 0; ep < 4; ep++) begin
            for (int v = 0; v <= 4; v++) applyStimulus(1'b1, 40 * ep + v);
            applyStimulus(1'b1, 40 * ep + 6);
        end

        // Randomised stream: mostly +1, with holds, gaps, jumps and resets
        cur = $urandom_range(0, 255);
        for (int i = 0; i < 800; i++) begin
            if (i % 250 == 249) doReset();
            r = $urandom_range(0, 99);
            if (r < 20) begin
                applyStimulus(1'b0, $urandom_range(0, 255));
            end else begin
                if (r < 75)      cur = (cur + 1) % 256;
                else if (r < 88) cur = cur;
                else if (r < 95) cur = $urandom_range(0, 255);
                else             cur = (cur + 2) % 256;
                applyStimulus(1'b1, cur);
            end
        end

        // Drain the pipeline
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
